// File: rtl/jtag_bus_pkg.sv
// Shared definitions for the JTAG bus-master sequencer: bus field widths
// and the state encoding of the transfer FSM.
package jtag_bus_pkg;

  localparam int ADDR_W  = 32;           // bus address / data width
  localparam int BURST_W = 8;            // burst size field (beats minus 1)
  localparam int BE_W    = 4;            // byte-enable field
  localparam int BEAT_W  = BURST_W + 1;  // beat counter: 256 beats without wrap

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQUEST  = 3'd1,
    ST_BEGIN    = 3'd2,
    ST_READ     = 3'd3,
    ST_PREFETCH = 3'd4,
    ST_WRITE    = 3'd5,
    ST_END      = 3'd6
  } state_t;

endpackage

// File: rtl/jtag_bus_master_ctrl.sv
// Single-burst bus master between the JTAG ping-pong buffer and the system
// bus. Latches a command, arbitrates, runs one read or write burst and keeps
// busy/done/error status for JTAG readback.
// BUF_ADDR_W must be at least 8 so a full 256-beat burst fits the buffer.
module jtag_bus_master_ctrl
  import jtag_bus_pkg::*;
#(
  parameter int BUF_ADDR_W = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  // command registers (already synchronised to i_clock)
  input  logic                  i_cmd_start,
  input  logic                  i_cmd_read,
  input  logic [ADDR_W-1:0]     i_cmd_address,
  input  logic [BURST_W-1:0]    i_cmd_burst_size,
  input  logic [BE_W-1:0]       i_cmd_byte_enables,
  output logic                  o_status_busy,
  output logic                  o_status_done,
  output logic                  o_status_error,
  // ping-pong buffer
  output logic [BUF_ADDR_W-1:0] o_buf_addr,
  output logic                  o_buf_we,
  output logic [ADDR_W-1:0]     o_buf_wdata,
  input  logic [ADDR_W-1:0]     i_buf_rdata,
  // system bus
  output logic                  o_request_transaction,
  input  logic                  i_transaction_granted,
  output logic                  o_begin_transaction_out,
  output logic [ADDR_W-1:0]     o_address_data_out,
  output logic [BURST_W-1:0]    o_burst_size_out,
  output logic [BE_W-1:0]       o_byte_enables_out,
  output logic                  o_read_n_write_out,
  output logic                  o_data_valid_out,
  output logic                  o_end_transaction_out,
  input  logic [ADDR_W-1:0]     i_address_data_in,
  input  logic                  i_data_valid_in,
  input  logic                  i_end_transaction_in,
  input  logic                  i_busy_in,
  input  logic                  i_error_in
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [BURST_W-1:0]  r_burst;
  logic [BE_W-1:0]     r_be;
  logic                r_rnw;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                r_req;
  logic                r_begin;
  logic                r_dvo;
  logic                r_end;

  logic                w_last_beat;
  logic                w_rd_store;
  logic [BEAT_W-1:0]   w_addr_cnt;

  // Last write beat is the one whose index equals the latched burst size.
  assign w_last_beat = (r_beat == {1'b0, r_burst});

  // A read beat is stored only when valid, error-free and inside the burst;
  // surplus beats from a misbehaving slave are dropped.
  assign w_rd_store = (r_state == ST_READ) && i_data_valid_in && !i_error_in &&
                      (r_beat <= {1'b0, r_burst});

  // Buffer address: the stored beat on reads, 0 while prefetching, and on
  // writes the beat whose data must appear on the bus next cycle (hold the
  // current beat while the slave stalls, otherwise look one ahead).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_addr_cnt = '0;
    unique case (r_state)
      ST_READ:  if (w_rd_store) w_addr_cnt = r_beat;
      ST_WRITE: w_addr_cnt = i_busy_in ? r_beat : r_beat + BEAT_W'(1);
      default:  w_addr_cnt = '0;
    endcase
  end

  // Transfer sequencer: state, latched command, beat counter, status and
  // the registered bus strobes.
  always_ff @(posedge i_clock) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_burst <= '0;
      r_be    <= '0;
      r_rnw   <= 1'b0;
      r_beat  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_req   <= 1'b0;
      r_begin <= 1'b0;
      r_dvo   <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      r_begin <= 1'b0;
      r_end   <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_cmd_start) begin
            r_addr  <= i_cmd_address;
            r_burst <= i_cmd_burst_size;
            r_be    <= i_cmd_byte_enables;
            r_rnw   <= i_cmd_read;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_req   <= 1'b1;
            r_state <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (i_transaction_granted) begin
            r_req   <= 1'b0;
            r_begin <= 1'b1;
            r_state <= ST_BEGIN;
          end
        end
        ST_BEGIN: begin
          r_beat  <= '0;
          r_state <= r_rnw ? ST_READ : ST_PREFETCH;
        end
        ST_READ: begin
          if (i_error_in) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            if (w_rd_store) r_beat <= r_beat + BEAT_W'(1);
            if (i_end_transaction_in) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_PREFETCH: begin
          if (i_error_in) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_dvo   <= 1'b1;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (i_error_in) begin
            r_dvo   <= 1'b0;
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (!i_busy_in) begin
            if (w_last_beat) begin
              r_dvo   <= 1'b0;
              r_end   <= 1'b1;
              r_state <= ST_END;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        ST_END: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_status_busy           = r_busy;
  assign o_status_done           = r_done;
  assign o_status_error          = r_error;
  assign o_request_transaction   = r_req;
  assign o_begin_transaction_out = r_begin;
  assign o_data_valid_out        = r_dvo;
  assign o_end_transaction_out   = r_end;

  // Address-phase fields are shown only during the single BEGIN cycle.
  assign o_burst_size_out   = r_begin ? r_burst : '0;
  assign o_byte_enables_out = r_begin ? r_be    : '0;
  assign o_read_n_write_out = r_begin & r_rnw;

  // Address in BEGIN, buffer data straight through during WRITE, else 0.
  assign o_address_data_out = r_begin              ? r_addr      :
                              (r_state == ST_WRITE) ? i_buf_rdata : '0;

  assign o_buf_we    = w_rd_store;
  assign o_buf_wdata = w_rd_store ? i_address_data_in : '0;
  assign o_buf_addr  = BUF_ADDR_W'(w_addr_cnt);

endmodule
